// File: rtl/keypad_debounce_scanner_if.sv
// Pin-side and consumer-side signals of the 4x4 keypad scanner.
// master: the scanner itself; slave: keypad pins plus the logic that consumes the key code.
interface keypad_debounce_scanner_if;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] key;
  logic       key_pressed;
  logic       key_strobe;

  modport master (
    output columnas,
    output key,
    output key_pressed,
    output key_strobe,
    input  filas
  );

  modport slave (
    input  columnas,
    input  key,
    input  key_pressed,
    input  key_strobe,
    output filas
  );
endinterface

// File: rtl/keypad_debounce_scanner.sv
// 4x4 keypad scanner: walks an active-low column strobe, debounces the synchronised rows
// and reports the first stable key as a 4-bit code with a one-cycle strobe.
module keypad_debounce_scanner #(
  parameter int unsigned SCAN_TICKS     = 27000,
  parameter int unsigned DEBOUNCE_TICKS = 540000
) (
  input  logic                             clk,
  input  logic                             rst,
  keypad_debounce_scanner_if.master        kp
);

  localparam int unsigned MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync_q, sync_d;
  logic [3:0]    row_s_q, row_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    key_q, key_d;
  logic          key_pressed_q, key_pressed_d;
  logic          key_strobe_q, key_strobe_d;
  logic [3:0]    columnas_q, columnas_d;
  logic [1:0]    first_low;
  logic          row_high;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  // Walk from row 3 down so the lowest-index low row is the last one written.
  always_comb begin
    first_low = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s_q[3 - i]) first_low = 2'(3 - i);
    end
  end

  assign row_high = row_s_q[row_q];

  always_comb begin
    sync_d        = kp.filas;
    row_s_d       = sync_q;
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    col_d         = col_q;
    row_d         = row_q;
    key_d         = key_q;
    key_pressed_d = key_pressed_q;
    key_strobe_d  = 1'b0;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_s_q != '1) begin
            row_d   = first_low;
            state_d = DEB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEB_PRESS: begin
        if (row_high) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d         = '0;
          key_d         = key_code(row_q, col_q);
          key_pressed_d = 1'b1;
          key_strobe_d  = 1'b1;
          state_d       = PRESSED;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (row_high) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (!row_high) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d         = '0;
          key_pressed_d = 1'b0;
          col_d         = col_q + 2'd1;
          state_d       = SCAN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase

    // Column drive is registered from the next index so it lands on the same edge as col_q.
    columnas_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SCAN;
      sync_q        <= '1;
      row_s_q       <= '1;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      key_q         <= '0;
      key_pressed_q <= 1'b0;
      key_strobe_q  <= 1'b0;
      columnas_q    <= 4'b1110;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      row_s_q       <= row_s_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      key_q         <= key_d;
      key_pressed_q <= key_pressed_d;
      key_strobe_q  <= key_strobe_d;
      columnas_q    <= columnas_d;
    end
  end

  assign kp.columnas    = columnas_q;
  assign kp.key         = key_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.key_strobe  = key_strobe_q;

endmodule

// File: tb/tb_keypad_debounce_scanner.sv
// Self-checking bench: emulates a 4x4 contact matrix and predicts scan/press/release
// timing arithmetically from the time since reset release.
module tb_keypad_debounce_scanner;
  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_debounce_scanner_if kif();

  keypad_debounce_scanner #(.SCAN_TICKS(SCAN), .DEBOUNCE_TICKS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // Closed contacts, bit index r*4+c.
  logic [15:0] keys = '0;
  logic [3:0]  filas_w;
  always_comb begin
    filas_w = '1;
    for (int r = 0; r < 4; r++) filas_w[r] = ~|(keys[r*4 +: 4] & ~kif.columnas);
  end
  assign kif.filas = filas_w;

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  logic [3:0] kmap [16];
  int tests = 0;
  int fails = 0;
  int n, nstrobe, nrise, nfall, rise_n, fall_n, bad_consec, bad_sp;
  logic [3:0] strobe_key;
  logic prev_p, prev_s;

  task automatic reinit_obs();
    n = 0; nstrobe = 0; nrise = 0; nfall = 0; rise_n = -1; fall_n = -1;
    bad_consec = 0; bad_sp = 0; prev_p = 1'b0; prev_s = 1'b0; strobe_key = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    n = cyc;
    if (kif.key_strobe) begin
      nstrobe++;
      strobe_key = kif.key;
      if (prev_s) bad_consec++;
      if (prev_p) bad_sp++;
    end
    if (kif.key_pressed && !prev_p) begin nrise++; rise_n = n; end
    if (!kif.key_pressed && prev_p) begin nfall++; fall_n = n; end
    prev_p = kif.key_pressed;
    prev_s = kif.key_strobe;
  endtask

  task automatic apply_reset(input logic [15:0] k);
    rst = 1'b0;
    keys = k;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    reinit_obs();
  endtask

  task automatic wait_rise(input int target, input int budget);
    for (int i = 0; i < budget && nrise < target; i++) tick();
  endtask

  task automatic wait_fall(input int target, input int budget);
    for (int i = 0; i < budget && nfall < target; i++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    apply_reset('0);
    #1;
    tests++; if (kif.columnas !== 4'b1110) begin fails++; $display("FAIL reset_columnas: got %b expected 1110", kif.columnas); end
    tests++; if (kif.key !== 4'h0) begin fails++; $display("FAIL reset_key: got %h expected 0", kif.key); end
    tests++; if (kif.key_pressed !== 1'b0) begin fails++; $display("FAIL reset_pressed: got %b expected 0", kif.key_pressed); end
    tests++; if (kif.key_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", kif.key_strobe); end
    for (int i = 0; i < 24; i++) begin
      tick();
      exp_col = ~(one << ((n / SCAN) % 4));
      tests++; if (kif.columnas !== exp_col) begin fails++; $display("FAIL scan_walk n=%0d: got %b expected %b", n, kif.columnas, exp_col); end
    end
    tests++; if (nrise != 0 || nstrobe != 0) begin fails++; $display("FAIL idle_no_press: got rises=%0d strobes=%0d expected 0/0", nrise, nstrobe); end
  endtask

  task automatic test_clean_press();
    int idx, c, exp_rise, rel, h;
    logic [15:0] k;
    logic [3:0] one, exp_col;
    one = 4'b0001;
    for (int it = 0; it < 4; it++) begin
      idx = (it == 0) ? 6 : int'($urandom_range(0, 15));
      c = idx % 4;
      k = '0; k[idx] = 1'b1;
      apply_reset(k);
      exp_rise = SCAN * (c + 1) + DEB;
      wait_rise(1, 200);
      tests++; if (rise_n != exp_rise) begin fails++; $display("FAIL press_latency key%0d: got n=%0d expected n=%0d", idx, rise_n, exp_rise); end
      tests++; if (nstrobe != 1 || strobe_key !== kmap[idx]) begin fails++; $display("FAIL press_strobe key%0d: got %0d strobes code %h expected 1 code %h", idx, nstrobe, strobe_key, kmap[idx]); end
      tests++; if (kif.key !== kmap[idx]) begin fails++; $display("FAIL press_key key%0d: got %h expected %h", idx, kif.key, kmap[idx]); end
      h = int'($urandom_range(0, 10));
      repeat (h) tick();
      keys = '0;
      rel = n;
      wait_fall(1, 60);
      tests++; if (fall_n != rel + 3 + DEB) begin fails++; $display("FAIL release_latency key%0d: got n=%0d expected n=%0d", idx, fall_n, rel + 3 + DEB); end
      tests++; if (kif.key !== kmap[idx]) begin fails++; $display("FAIL key_hold key%0d: got %h expected %h", idx, kif.key, kmap[idx]); end
      exp_col = ~(one << ((c + 1) % 4));
      tests++; if (kif.columnas !== exp_col) begin fails++; $display("FAIL post_release_col key%0d: got %b expected %b", idx, kif.columnas, exp_col); end
      tests++; if (nstrobe != 1 || bad_consec != 0 || bad_sp != 0) begin fails++; $display("FAIL strobe_rules key%0d: got strobes=%0d consec=%0d while_pressed=%0d expected 1/0/0", idx, nstrobe, bad_consec, bad_sp); end
    end
  endtask

  task automatic test_bounce();
    int phases, rel;
    apply_reset('0);
    while (n < int'($urandom_range(4, 10))) tick();
    phases = int'($urandom_range(2, 5));
    for (int p = 0; p < phases; p++) begin
      keys[14] = (p % 2 == 0);
      repeat (3) tick();
    end
    keys[14] = 1'b1;
    wait_rise(1, 200);
    tests++; if (nstrobe != 1 || strobe_key !== 4'hF) begin fails++; $display("FAIL bounce_press: got %0d strobes code %h expected 1 code f", nstrobe, strobe_key); end
    tests++; if (kif.key !== 4'hF) begin fails++; $display("FAIL bounce_key: got %h expected f", kif.key); end
    repeat (2) tick();
    phases = int'($urandom_range(1, 3));
    for (int p = 0; p < 2 * phases; p++) begin
      keys[14] = (p % 2 == 1);
      repeat (3) tick();
    end
    tests++; if (nfall != 0 || kif.key_pressed !== 1'b1) begin fails++; $display("FAIL bounce_release_glitch: got falls=%0d pressed=%b expected 0/1", nfall, kif.key_pressed); end
    keys[14] = 1'b0;
    rel = n;
    wait_fall(1, 60);
    tests++; if (fall_n != rel + 3 + DEB) begin fails++; $display("FAIL bounce_release_latency: got n=%0d expected n=%0d", fall_n, rel + 3 + DEB); end
    tests++; if (nstrobe != 1 || nrise != 1 || bad_consec != 0 || bad_sp != 0) begin fails++; $display("FAIL bounce_single: got strobes=%0d rises=%0d expected 1/1", nstrobe, nrise); end
  endtask

  task automatic test_glitch();
    int c, idx, s;
    logic [15:0] k;
    c = int'($urandom_range(1, 3));
    idx = int'($urandom_range(0, 3)) * 4 + c;
    k = '0; k[idx] = 1'b1;
    apply_reset(k);
    wait_rise(1, 200);
    keys = '0;
    wait_fall(1, 60);
    s = fall_n + SCAN * ((4 - ((c + 1) % 4)) % 4);
    while (n < s) tick();
    keys[0] = 1'b1;
    repeat (5) tick();
    keys[0] = 1'b0;
    while (n < s + 7) tick();
    tests++; if (kif.columnas !== 4'b1110) begin fails++; $display("FAIL glitch_col_hold: got %b expected 1110", kif.columnas); end
    while (n < s + 11) tick();
    tests++; if (kif.columnas !== 4'b1110) begin fails++; $display("FAIL glitch_rescan_c0: got %b expected 1110", kif.columnas); end
    tick();
    tests++; if (kif.columnas !== 4'b1101) begin fails++; $display("FAIL glitch_advance_c1: got %b expected 1101", kif.columnas); end
    repeat (30) tick();
    tests++; if (nstrobe != 1 || nrise != 1 || kif.key_pressed !== 1'b0) begin fails++; $display("FAIL glitch_no_strobe: got strobes=%0d rises=%0d pressed=%b expected 1/1/0", nstrobe, nrise, kif.key_pressed); end
    tests++; if (kif.key !== kmap[idx]) begin fails++; $display("FAIL glitch_key_kept: got %h expected %h", kif.key, kmap[idx]); end
  endtask

  task automatic test_two_keys();
    int rel, exp2;
    logic [15:0] k;
    k = '0; k[4] = 1'b1; k[8] = 1'b1;
    apply_reset(k);
    wait_rise(1, 200);
    tests++; if (rise_n != SCAN + DEB || kif.key !== 4'h4) begin fails++; $display("FAIL same_col_lowest: got n=%0d key %h expected n=%0d key 4", rise_n, kif.key, SCAN + DEB); end
    keys[8] = 1'b0;
    keys[10] = 1'b1;
    repeat (30) tick();
    tests++; if (nstrobe != 1 || kif.key !== 4'h4 || kif.key_pressed !== 1'b1) begin fails++; $display("FAIL first_key_lock: got strobes=%0d key %h pressed=%b expected 1/4/1", nstrobe, kif.key, kif.key_pressed); end
    keys[4] = 1'b0;
    rel = n;
    wait_fall(1, 60);
    tests++; if (fall_n != rel + 3 + DEB) begin fails++; $display("FAIL lock_release: got n=%0d expected n=%0d", fall_n, rel + 3 + DEB); end
    exp2 = fall_n + 2 * SCAN + DEB;
    wait_rise(2, 100);
    tests++; if (nrise != 2 || rise_n != exp2 || kif.key !== 4'h9) begin fails++; $display("FAIL second_key: got rises=%0d n=%0d key %h expected 2/%0d/9", nrise, rise_n, kif.key, exp2); end
    tests++; if (nstrobe != 2 || bad_consec != 0 || bad_sp != 0) begin fails++; $display("FAIL second_strobe: got strobes=%0d expected 2", nstrobe); end
  endtask

  task automatic test_reset_mid_press();
    logic [15:0] k;
    k = '0; k[12] = 1'b1;
    apply_reset(k);
    wait_rise(1, 200);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    tests++; if (kif.key !== 4'h0 || kif.columnas !== 4'b1110) begin fails++; $display("FAIL async_reset_outs: got key %h col %b expected 0/1110", kif.key, kif.columnas); end
    tests++; if (kif.key_pressed !== 1'b0 || kif.key_strobe !== 1'b0) begin fails++; $display("FAIL async_reset_flags: got pressed=%b strobe=%b expected 0/0", kif.key_pressed, kif.key_strobe); end
    @(negedge clk);
    rst = 1'b1;
    reinit_obs();
    wait_rise(1, 200);
    tests++; if (rise_n != SCAN + DEB || nstrobe != 1 || strobe_key !== 4'hE) begin fails++; $display("FAIL repress_after_reset: got n=%0d strobes=%0d code %h expected %0d/1/e", rise_n, nstrobe, strobe_key, SCAN + DEB); end
  endtask

  initial begin
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA,
             4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC,
             4'hE, 4'h0, 4'hF, 4'hD};
    reinit_obs();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_two_keys();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
